// File: rtl/shift_rows.sv
// shift_rows: AES ShiftRows / InvShiftRows byte permutation with one register
// stage. The state is column-major (state[r][c] = byte r+4c, byte 0 in the
// MSBs). Row r is rotated left by r bytes in forward mode and right by r bytes
// in inverse mode. Row 0 never moves.
module shift_rows (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         inv,
  input  logic [127:0] shift_rows_in,
  output logic [127:0] shift_row_out,
  output logic         out_valid
);

  logic [127:0] data_d, data_q;
  logic         vld_d,  vld_q;

  // Forward ShiftRows: out[r][c] = in[r][(c+r) mod 4]
  function automatic logic [127:0] fwd_perm(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+r)%4))) +: 8];
      end
    end
    return o;
  endfunction

  // Inverse ShiftRows: out[r][c] = in[r][(c-r) mod 4], written as (c+4-r)
  // so the modulo operand never goes negative.
  function automatic logic [127:0] inv_perm(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+4-r)%4))) +: 8];
      end
    end
    return o;
  endfunction

  // Next-state: capture the permuted sample only when qualified, otherwise
  // hold so unqualified (possibly X) inputs never reach the register.
  always_comb begin
    data_d = data_q;
    vld_d  = in_valid;
    if (in_valid) begin
      data_d = inv ? inv_perm(shift_rows_in) : fwd_perm(shift_rows_in);
    end
  end

  // Output register; reset clears both data and valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign shift_row_out = data_q;
  assign out_valid     = vld_q;

endmodule

// File: tb/tb_shift_rows.sv
// Self-checking bench for shift_rows: known vectors, back-to-back samples,
// random round-trips against a queue-based row-rotation model, hold behaviour
// and asynchronous reset.
module tb_shift_rows;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         inv;
  logic [127:0] shift_rows_in;
  logic [127:0] shift_row_out;
  logic         out_valid;

  int n_cmp;
  int n_fail;

  shift_rows dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .inv           (inv),
    .shift_rows_in (shift_rows_in),
    .shift_row_out (shift_row_out),
    .out_valid     (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: split the state into its four rows, rotate each row as a queue
  // r times (left for forward, right for inverse), and reassemble.
  function automatic logic [127:0] ref_shift(input logic [127:0] x, input logic mode_inv);
    logic [7:0]   row[$];
    logic [127:0] y;
    y = '0;
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < 4; c++) row.push_back(x[8*(15-(r+4*c)) +: 8]);
      for (int k = 0; k < r; k++) begin
        if (!mode_inv) row.push_back(row.pop_front());
        else           row.push_front(row.pop_back());
      end
      for (int c = 0; c < 4; c++) y[8*(15-(r+4*c)) +: 8] = row[c];
    end
    return y;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; inv = 1'b0; shift_rows_in = '0;
    #3;
    n_cmp++;
    if (shift_row_out !== 128'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: out=%h vld=%b, expected out=0 vld=0", shift_row_out, out_valid);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (shift_row_out !== 128'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: out=%h vld=%b, expected out=0 vld=0", shift_row_out, out_valid);
    end
  endtask

  task automatic test_vectors();
    logic [127:0] vin [3];
    logic         vinv[3];
    logic [127:0] vexp[3];
    vin[0] = 128'h01020304_05060708_09101112_13141516; vinv[0] = 1'b0;
    vexp[0] = 128'h01061116_05101504_09140308_13020712;
    vin[1] = 128'h49ded289_45db96f1_7f39871a_7702533b; vinv[1] = 1'b0;
    vexp[1] = 128'h49db873b_45395389_7f02d2f1_77de961a;
    vin[2] = 128'h49db873b_45395389_7f02d2f1_77de961a; vinv[2] = 1'b1;
    vexp[2] = 128'h49ded289_45db96f1_7f39871a_7702533b;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; inv = vinv[i]; shift_rows_in = vin[i];
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (shift_row_out !== vexp[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL vector%0d: out=%h vld=%b, expected out=%h vld=1", i, shift_row_out, out_valid, vexp[i]);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || shift_row_out !== vexp[i]) begin
        n_fail++;
        $display("FAIL vector%0d_pulse: out=%h vld=%b, expected out=%h vld=0", i, shift_row_out, out_valid, vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b, ea, eb;
    a  = 128'hac73cf7b_efc111df_13b5d6b5_45235ab8;
    b  = 128'h49ded289_45db96f1_7f39871a_7702533b;
    ea = 128'hacc1d6b8_efb55a7b_1323cfdf_457311b5;
    eb = 128'h49db873b_45395389_7f02d2f1_77de961a;
    in_valid = 1'b1; inv = 1'b0; shift_rows_in = a;
    step();
    shift_rows_in = b;
    n_cmp++;
    if (shift_row_out !== ea || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: out=%h vld=%b, expected out=%h vld=1", shift_row_out, out_valid, ea);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (shift_row_out !== eb || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: out=%h vld=%b, expected out=%h vld=1", shift_row_out, out_valid, eb);
    end
    step();
    n_cmp++;
    if (shift_row_out !== eb || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: out=%h vld=%b, expected out=%h vld=0", shift_row_out, out_valid, eb);
    end
  endtask

  task automatic test_roundtrip();
    logic [127:0] x, y;
    for (int i = 0; i < 20; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1; inv = 1'b0; shift_rows_in = x;
      step();
      y = shift_row_out;
      n_cmp++;
      if (y !== ref_shift(x, 1'b0) || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rt_fwd%0d: out=%h vld=%b, expected out=%h vld=1", i, y, out_valid, ref_shift(x, 1'b0));
      end
      inv = 1'b1; shift_rows_in = y;
      step();
      n_cmp++;
      if (shift_row_out !== x || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rt_inv%0d: out=%h vld=%b, expected out=%h vld=1", i, shift_row_out, out_valid, x);
      end
      inv = 1'b1; shift_rows_in = x;
      step();
      n_cmp++;
      if (shift_row_out !== ref_shift(x, 1'b1)) begin
        n_fail++;
        $display("FAIL rand_inv%0d: out=%h, expected %h", i, shift_row_out, ref_shift(x, 1'b1));
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_hold();
    logic [127:0] x, e;
    x = {$urandom, $urandom, $urandom, $urandom};
    e = ref_shift(x, 1'b0);
    in_valid = 1'b1; inv = 1'b0; shift_rows_in = x;
    step();
    in_valid = 1'b0; inv = 1'bx; shift_rows_in = 'x;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (shift_row_out !== e || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_x%0d: out=%h vld=%b, expected out=%h vld=0", i, shift_row_out, out_valid, e);
      end
      inv = $urandom_range(0, 1); shift_rows_in = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic test_async_reset();
    logic [127:0] x;
    x = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    in_valid = 1'b1; inv = 1'b0; shift_rows_in = x;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || shift_row_out !== ref_shift(x, 1'b0)) begin
      n_fail++;
      $display("FAIL arst_pre: out=%h vld=%b, expected out=%h vld=1", shift_row_out, out_valid, ref_shift(x, 1'b0));
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (shift_row_out !== 128'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: out=%h vld=%b, expected out=0 vld=0", shift_row_out, out_valid);
    end
    step();
    n_cmp++;
    if (shift_row_out !== 128'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_held: out=%h vld=%b, expected out=0 vld=0", shift_row_out, out_valid);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (shift_row_out !== 128'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_release: out=%h vld=%b, expected out=0 vld=0", shift_row_out, out_valid);
    end
    x = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; inv = 1'b1; shift_rows_in = x;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (shift_row_out !== ref_shift(x, 1'b1) || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_capture: out=%h vld=%b, expected out=%h vld=1", shift_row_out, out_valid, ref_shift(x, 1'b1));
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_roundtrip();
    test_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
